// File: rtl/load_use_hazard_unit_pkg.sv
// Shared LC-3b pipeline types: opcodes, register index, hazard FSM state
// and the load classifier used by decode and by the hazard unit.
package load_use_hazard_unit_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_BUBBLE = 2'd1,
    HZ_FROZEN = 2'd2
  } lc3b_hazard_state;

  function automatic logic lc3b_is_load(input lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
  endfunction

endpackage

// File: rtl/load_use_hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = &count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use interlock: one-cycle IF/ID stall behind an in-flight load,
// whole-pipe freeze on data-memory wait, flush bubbles, debug counters.
//
// state      | meaning
// HZ_RUN     | pipeline flowing, no interlock last cycle
// HZ_BUBBLE  | a load-use bubble was inserted last cycle
// HZ_FROZEN  | pipeline held last cycle waiting on data memory
module load_use_hazard_unit
  import load_use_hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  lc3b_opcode       id_opcode,
  input  lc3b_reg          id_dr,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic             dmem_stall,
  input  logic             flush,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             de_ex_bubble,
  output logic             pipe_freeze,
  output lc3b_hazard_state hazard_state,
  output logic [15:0]      stall_cycles,
  output logic             mem_timeout
);

  localparam int FREEZE_BITS = $clog2(MEM_TIMEOUT + 1);
  localparam int FREEZE_W    = (FREEZE_BITS > 8) ? FREEZE_BITS : 8;

  logic             ex_valid;
  logic             ex_is_load;
  lc3b_reg          ex_dr;
  logic             src_match;
  logic             hazard;
  logic             freeze_active;
  lc3b_hazard_state state;
  lc3b_hazard_state state_next;
  logic [FREEZE_W-1:0] freeze_count;
  logic             unused_stall_max;
  logic             unused_freeze_max;

  assign src_match = (id_sr1_used && (id_sr1 == ex_dr)) ||
                     (id_sr2_used && (id_sr2 == ex_dr));

  // Gating with reset_n forces every combinational output low during reset.
  assign hazard = reset_n && id_valid && ex_valid && ex_is_load && src_match &&
                  !flush && !dmem_stall;
  assign freeze_active = reset_n && dmem_stall;

  assign pipe_freeze  = freeze_active;
  assign pc_hold      = freeze_active | hazard;
  assign if_id_hold   = freeze_active | hazard;
  assign de_ex_bubble = reset_n && !dmem_stall && (hazard | flush);
  assign hazard_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_dr      <= '0;
    end else if (!dmem_stall) begin
      if (flush || hazard) begin
        ex_valid   <= 1'b0;
        ex_is_load <= 1'b0;
      end else begin
        ex_valid   <= id_valid;
        ex_is_load <= id_valid && lc3b_is_load(id_opcode);
        ex_dr      <= id_dr;
      end
    end
  end

  always_comb begin
    state_next = HZ_RUN;
    if (dmem_stall) begin
      state_next = HZ_FROZEN;
    end else if (hazard) begin
      state_next = HZ_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HZ_RUN;
    end else begin
      state <= state_next;
    end
  end

  sat_counter #(.WIDTH(16)) u_stall_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hazard),
    .clr     (1'b0),
    .count   (stall_cycles),
    .at_max  (unused_stall_max)
  );

  sat_counter #(.WIDTH(FREEZE_W)) u_freeze_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (dmem_stall),
    .clr     (!dmem_stall),
    .count   (freeze_count),
    .at_max  (unused_freeze_max)
  );

  // The frozen cycle that brings the timer to MEM_TIMEOUT sets the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_timeout <= 1'b0;
    end else if (dmem_stall && (freeze_count >= FREEZE_W'(MEM_TIMEOUT - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed and randomized check of load_use_hazard_unit against a
// cycle-level reference model of the interlock rules.
module tb_load_use_hazard_unit;
  import load_use_hazard_unit_pkg::*;

  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             id_valid;
  lc3b_opcode       id_opcode;
  lc3b_reg          id_dr, id_sr1, id_sr2;
  logic             id_sr1_used, id_sr2_used;
  logic             dmem_stall, flush;
  logic             pc_hold, if_id_hold, de_ex_bubble, pipe_freeze;
  lc3b_hazard_state hazard_state;
  logic [15:0]      stall_cycles;
  logic             mem_timeout;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit      m_ex_valid;
  bit      m_ex_load;
  int      m_ex_dr;
  int      m_state;      // 0 run, 1 bubble, 2 frozen
  int      m_stalls;
  int      m_run;
  bit      m_to;
  bit      exp_h;

  logic    obs_bubble, obs_hold, obs_freeze;

  always #5 clk = ~clk;

  load_use_hazard_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_dr        (id_dr),
    .id_sr1       (id_sr1),
    .id_sr2       (id_sr2),
    .id_sr1_used  (id_sr1_used),
    .id_sr2_used  (id_sr2_used),
    .dmem_stall   (dmem_stall),
    .flush        (flush),
    .pc_hold      (pc_hold),
    .if_id_hold   (if_id_hold),
    .de_ex_bubble (de_ex_bubble),
    .pipe_freeze  (pipe_freeze),
    .hazard_state (hazard_state),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_ex_valid = 0; m_ex_load = 0; m_ex_dr = 0;
    m_state = 0; m_stalls = 0; m_run = 0; m_to = 0;
  endtask

  task automatic set_id(input bit v, input lc3b_opcode op, input int dr,
                        input int s1, input int s2, input bit u1, input bit u2);
    id_valid = v; id_opcode = op;
    id_dr = lc3b_reg'(dr); id_sr1 = lc3b_reg'(s1); id_sr2 = lc3b_reg'(s2);
    id_sr1_used = u1; id_sr2_used = u2;
  endtask

  task automatic check_outputs(input string tag);
    bit match;
    match = (id_sr1_used && int'(id_sr1) == m_ex_dr) || (id_sr2_used && int'(id_sr2) == m_ex_dr);
    exp_h = id_valid && m_ex_valid && m_ex_load && match && !flush && !dmem_stall;
    chk({tag, ".freeze"}, 32'(pipe_freeze), 32'(dmem_stall));
    chk({tag, ".pc_hold"}, 32'(pc_hold), 32'(dmem_stall | exp_h));
    chk({tag, ".if_id_hold"}, 32'(if_id_hold), 32'(dmem_stall | exp_h));
    chk({tag, ".bubble"}, 32'(de_ex_bubble), 32'(!dmem_stall && (exp_h || flush)));
    chk({tag, ".state"}, 32'(hazard_state), 32'(m_state));
    chk({tag, ".stalls"}, 32'(stall_cycles), 32'(m_stalls));
    chk({tag, ".timeout"}, 32'(mem_timeout), 32'(m_to));
    if (m_state == 1)
      chk({tag, ".no_hazard_after_bubble"}, 32'(if_id_hold && !dmem_stall), 32'(0));
    obs_bubble = de_ex_bubble; obs_hold = if_id_hold; obs_freeze = pipe_freeze;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step(input string tag);
    bit is_ld;
    #1;
    check_outputs(tag);
    @(posedge clk);
    is_ld = (id_opcode == op_ldr) || (id_opcode == op_ldb) || (id_opcode == op_ldi);
    if (!dmem_stall) begin
      if (flush || exp_h) begin
        m_ex_valid = 0; m_ex_load = 0;
      end else begin
        m_ex_valid = id_valid; m_ex_load = id_valid && is_ld; m_ex_dr = int'(id_dr);
      end
    end
    if (exp_h && m_stalls < 65535) m_stalls++;
    m_run = dmem_stall ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_to = 1;
    m_state = dmem_stall ? 2 : (exp_h ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".freeze"}, 32'(pipe_freeze), 0);
    chk({tag, ".pc_hold"}, 32'(pc_hold), 0);
    chk({tag, ".if_id_hold"}, 32'(if_id_hold), 0);
    chk({tag, ".bubble"}, 32'(de_ex_bubble), 0);
    chk({tag, ".state"}, 32'(hazard_state), 32'(HZ_RUN));
    chk({tag, ".stalls"}, 32'(stall_cycles), 0);
    chk({tag, ".timeout"}, 32'(mem_timeout), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    set_id(1, op_add, 1, 1, 1, 1, 1);
    dmem_stall = 1'b1; flush = 1'b1;
    m_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; dmem_stall = 0; flush = 0;
    set_id(0, op_br, 0, 0, 0, 0, 0);
    step("idle");

    // LDR R2 ; ADD R3,R2,R1 back to back
    set_id(1, op_ldr, 2, 6, 0, 1, 0);  step("lu_load");
    set_id(1, op_add, 3, 2, 1, 1, 1);  step("lu_use");
    chk("lu_bubble", 32'(obs_bubble), 1);
    step("lu_use_retry");
    chk("lu_retry_bubble", 32'(obs_bubble), 0);
    chk("lu_stalls", 32'(stall_cycles), 1);
    set_id(0, op_br, 0, 0, 0, 0, 0);   step("lu_drain");

    // LDR R2 ; NOP ; ADD R3,R2,R1
    set_id(1, op_ldr, 2, 6, 0, 1, 0);  step("gap_load");
    set_id(1, op_br, 0, 0, 0, 0, 0);   step("gap_nop");
    set_id(1, op_add, 3, 2, 1, 1, 1);  step("gap_use");
    chk("gap_hold", 32'(obs_hold), 0);
    chk("gap_stalls", 32'(stall_cycles), 1);

    // LDB R4 ; STR with decoy sr2
    set_id(1, op_ldb, 4, 1, 0, 1, 0);  step("decoy_load");
    set_id(1, op_str, 0, 4, 4, 1, 0);  step("decoy_use");
    chk("decoy_bubble", 32'(obs_bubble), 1);
    step("decoy_retry");
    set_id(1, op_ldb, 4, 1, 0, 1, 0);  step("decoy2_load");
    set_id(1, op_str, 0, 4, 4, 0, 0);  step("decoy2_use");
    chk("decoy2_bubble", 32'(obs_bubble), 0);

    // hazard coincident with a 3-cycle memory stall
    set_id(1, op_ldr, 5, 0, 0, 1, 0);  step("frz_load");
    set_id(1, op_add, 1, 5, 0, 1, 0);
    dmem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step("frz_hold");
      chk("frz_freeze", 32'(obs_freeze), 1);
      chk("frz_nobubble", 32'(obs_bubble), 0);
    end
    dmem_stall = 0;                     step("frz_release");
    chk("frz_bubble", 32'(obs_bubble), 1);
    step("frz_retry");

    // flush with a load in the shadow and a matching consumer
    set_id(1, op_ldr, 6, 0, 0, 1, 0);  step("fl_load");
    set_id(1, op_add, 1, 6, 6, 1, 1); flush = 1;
    step("fl_use");
    chk("fl_bubble", 32'(obs_bubble), 1);
    chk("fl_hold", 32'(obs_hold), 0);
    flush = 0;                          step("fl_after");

    // memory timeout after TIMEOUT frozen cycles, sticky afterwards
    dmem_stall = 1;
    for (int i = 0; i < TIMEOUT; i++) step("to_hold");
    chk("to_set", 32'(mem_timeout), 1);
    dmem_stall = 0;                     step("to_drop");
    chk("to_sticky", 32'(mem_timeout), 1);

    // async reset mid-freeze
    dmem_stall = 1;
    step("rst_frz"); step("rst_frz");
    #2 reset_n = 0;
    #1 check_all_zero("rst_mid");
    m_reset();
    @(negedge clk);
    reset_n = 1; dmem_stall = 0;
    set_id(0, op_br, 0, 0, 0, 0, 0);
    step("rst_after");
    chk("rst_state", 32'(hazard_state), 32'(HZ_RUN));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      lc3b_opcode op;
      if ($urandom_range(0, 9) < 4) begin
        case ($urandom_range(0, 2))
          0: op = op_ldr;
          1: op = op_ldb;
          default: op = op_ldi;
        endcase
      end else begin
        op = lc3b_opcode'(4'($urandom));
      end
      set_id($urandom_range(0, 9) < 8, op, int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom));
      dmem_stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
